// File: rtl/ex_result_buffer.sv
// ex_result_buffer
//   Two-entry elastic buffer between the ALU and the memory/writeback stage.
//   The head entry ("main") drives the outputs, and a second ("skid") entry
//   absorbs the one beat that can arrive after the consumer stalls. Because of
//   the skid entry, in_ready is simply the inverse of the registered skid
//   valid bit, so the consumer stall never reaches the execute stage
//   combinationally.
//
//   Optional feature macro: EX_OVF_TRAP_EN
//     defined   : a beat with in_chk_over && in_over is stored with exc = 1 and
//                 wen = 0, and it sets ovf_sticky (cleared only by reset).
//     undefined : exc is always 0, wen passes through, ovf_sticky is tied 0.
//
// Ports
//   CLK, nRST             clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready is registered)
//   in_result, in_zero, in_neg, in_over, in_chk_over, in_wsel, in_wen
//                         ALU result, flags and register-write control
//   out_valid / out_ready downstream handshake for the head entry
//   out_result, out_zero, out_neg, out_over, out_wsel, out_wen, out_exc
//                         head entry fields
//   flush                 synchronous discard of every held entry
//   ovf_sticky            overflow trap seen since reset
module ex_result_buffer #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_result,
  input  logic          in_zero,
  input  logic          in_neg,
  input  logic          in_over,
  input  logic          in_chk_over,
  input  logic [RW-1:0] in_wsel,
  input  logic          in_wen,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_zero,
  output logic          out_neg,
  output logic          out_over,
  output logic [RW-1:0] out_wsel,
  output logic          out_wen,
  output logic          out_exc,
  input  logic          flush,
  output logic          ovf_sticky
);

  typedef struct packed {
    logic [DW-1:0] result;
    logic          zero;
    logic          neg;
    logic          over;
    logic [RW-1:0] wsel;
    logic          wen;
    logic          exc;
  } entry_t;

  entry_t in_ent;
  entry_t main_q;
  entry_t skid_q;
  logic   main_vld;
  logic   skid_vld;

  logic   in_trap;
  logic   accept;
  logic   pop;
  logic   load_main_in;
  logic   load_main_skid;
  logic   load_skid;

`ifdef EX_OVF_TRAP_EN
  assign in_trap = in_chk_over & in_over;
`else
  logic unused_chk_over;
  assign unused_chk_over = in_chk_over;
  assign in_trap         = 1'b0;
`endif

  // Incoming beat as it will be stored; a trapping op loses its register write.
  always_comb begin
    in_ent.result = in_result;
    in_ent.zero   = in_zero;
    in_ent.neg    = in_neg;
    in_ent.over   = in_over;
    in_ent.wsel   = in_wsel;
    in_ent.wen    = in_wen & ~in_trap;
    in_ent.exc    = in_trap;
  end

  assign in_ready  = ~skid_vld;
  assign out_valid = main_vld;

  assign accept = in_valid & ~skid_vld;
  assign pop    = main_vld & out_ready;

  // A new beat goes straight to the head when the head is free or leaving this
  // cycle; otherwise it parks in the skid entry. accept already implies the
  // skid is empty, so the two head-load sources are mutually exclusive.
  assign load_main_in   = accept & (~main_vld | pop);
  assign load_main_skid = skid_vld & pop;
  assign load_skid      = accept & main_vld & ~pop;

  // Stage boundary: occupancy (valid bits). flush wins over any accept.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      main_vld <= skid_vld | accept | (main_vld & ~pop);
      skid_vld <= skid_vld ? ~pop : load_skid;
    end
  end

  // Stage boundary: payload. Loads only on accept or skid->head move and is
  // otherwise left untouched (flush does not disturb it).
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_skid) begin
        main_q <= skid_q;
      end else if (load_main_in) begin
        main_q <= in_ent;
      end
      if (load_skid) begin
        skid_q <= in_ent;
      end
    end
  end

  assign out_result = main_q.result;
  assign out_zero   = main_q.zero;
  assign out_neg    = main_q.neg;
  assign out_over   = main_q.over;
  assign out_wsel   = main_q.wsel;
  assign out_wen    = main_q.wen;
  assign out_exc    = main_q.exc;

`ifdef EX_OVF_TRAP_EN
  // A trapping beat accepted on a flush edge is discarded before it was ever
  // held, so it does not count as seen.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ovf_sticky <= 1'b0;
    end else if (accept & in_trap & ~flush) begin
      ovf_sticky <= 1'b1;
    end
  end
`else
  assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_ex_result_buffer.sv
// tb_ex_result_buffer
//   Randomized + directed bench for ex_result_buffer. A reference model keeps
//   the buffer contents as a queue of expected beats plus an occupancy count;
//   a separate monitor compares the DUT head against the queue head on every
//   cycle and pops it when the DUT hands it off.
module tb_ex_result_buffer;
  localparam int DW = 32;
  localparam int RW = 5;
`ifdef EX_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          CLK;
  logic          nRST;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_result;
  logic          in_zero;
  logic          in_neg;
  logic          in_over;
  logic          in_chk_over;
  logic [RW-1:0] in_wsel;
  logic          in_wen;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_zero;
  logic          out_neg;
  logic          out_over;
  logic [RW-1:0] out_wsel;
  logic          out_wen;
  logic          out_exc;
  logic          flush;
  logic          ovf_sticky;

  ex_result_buffer #(.DW(DW), .RW(RW)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_neg(in_neg), .in_over(in_over),
    .in_chk_over(in_chk_over), .in_wsel(in_wsel), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_neg(out_neg), .out_over(out_over),
    .out_wsel(out_wsel), .out_wen(out_wen), .out_exc(out_exc),
    .flush(flush), .ovf_sticky(ovf_sticky)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] result;
    logic          zero;
    logic          neg;
    logic          over;
    logic [RW-1:0] wsel;
    logic          wen;
    logic          exc;
  } beat_t;

  beat_t exp_q[$];
  int    occ      = 0;
  bit    sticky_m = 1'b0;
  bit    last_acc = 1'b0;
  int    n_chk    = 0;
  int    n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference model: a buffer of capacity two, FIFO order, cleared by flush.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      occ = 0;
      exp_q.delete();
      sticky_m = 1'b0;
      last_acc = 1'b0;
    end else begin
      bit    acc;
      bit    pp;
      beat_t b;
      acc = in_valid && (occ < 2);
      pp  = (occ > 0) && out_ready;
      last_acc = acc;
      b.result = in_result;
      b.zero   = in_zero;
      b.neg    = in_neg;
      b.over   = in_over;
      b.wsel   = in_wsel;
      b.exc    = TRAP && in_chk_over && in_over;
      b.wen    = in_wen && !b.exc;
      if (flush) begin
        occ = 0;
        exp_q.delete();
      end else begin
        occ = occ + int'(acc) - int'(pp);
        if (acc) exp_q.push_back(b);
        if (acc && b.exc) sticky_m = 1'b1;
      end
    end
  end

  // Monitor: compares the visible head and handshake state with the model.
  always @(negedge CLK) begin
    if (nRST) begin
      check("out_valid", out_valid, occ > 0);
      check("in_ready", in_ready, occ < 2);
      check("ovf_sticky", ovf_sticky, sticky_m);
      check("state_01", dut.skid_vld && !dut.main_vld, 1'b0);
      if (out_valid && exp_q.size() > 0) begin
        check("out_result", out_result, exp_q[0].result);
        check("out_fields", {out_zero, out_neg, out_over, out_wsel, out_wen, out_exc},
              {exp_q[0].zero, exp_q[0].neg, exp_q[0].over, exp_q[0].wsel,
               exp_q[0].wen, exp_q[0].exc});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] r, input bit o, input bit c,
                       input logic [RW-1:0] ws, input bit we, input bit ordy, input bit fl);
    in_valid    = v;
    in_result   = r;
    in_zero     = (r == '0);
    in_neg      = r[DW-1];
    in_over     = o;
    in_chk_over = c;
    in_wsel     = ws;
    in_wen      = we;
    out_ready   = ordy;
    flush       = fl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input bit ordy, input int n);
    drive(0, '0, 0, 0, '0, 0, ordy, 0);
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    nRST = 1'b0;
    drive(0, '0, 0, 0, '0, 0, 0, 0);
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_outputs", {out_result, out_zero, out_neg, out_over, out_wsel, out_wen, out_exc},
          '0);
    check("rst_sticky", ovf_sticky, 1'b0);
    #9 nRST = 1'b1;
    tick();

    // Single beat, visible one edge after acceptance, gone after the pop edge.
    drive(1, 32'h0000_0005, 0, 0, 5'd3, 1, 1, 0);
    tick();
    check("single_valid", out_valid, 1'b1);
    check("single_result", out_result, 32'h5);
    check("single_ctl", {out_wsel, out_wen}, {5'd3, 1'b1});
    drive(0, '0, 0, 0, '0, 0, 1, 0);
    tick();
    check("single_popped", out_valid, 1'b0);

    // Stream 0x10..0x17 with a three-cycle consumer stall.
    idx = 0;
    for (cyc = 0; cyc < 40 && idx < 8; cyc++) begin
      drive(1, 32'h10 + idx, 0, 0, 5'(idx), 1, !(cyc >= 2 && cyc <= 4), 0);
      tick();
      if (last_acc) idx++;
    end
    check("stream_done", idx, 8);
    idle(1, 4);
    check("stream_drained", exp_q.size(), 0);

    // Fill, then flush with an incoming beat that must never appear.
    drive(1, 32'hA1, 0, 0, 5'd1, 1, 0, 0);
    tick();
    drive(1, 32'hA2, 0, 0, 5'd2, 1, 0, 0);
    tick();
    check("full_in_ready", in_ready, 1'b0);
    drive(1, 32'hDEAD, 0, 0, 5'd9, 1, 0, 1);
    tick();
    check("flush_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    idle(1, 3);
    check("flush_stays_empty", out_valid, 1'b0);

    // Overflow trap beat, then the same beat with overflow checking off.
    drive(1, 32'h8000_0000, 1, 1, 5'd7, 1, 0, 0);
    tick();
    check("trap_exc", out_exc, TRAP);
    check("trap_wen", out_wen, !TRAP);
    check("trap_sticky", ovf_sticky, TRAP);
    idle(1, 1);
    drive(1, 32'h8000_0000, 1, 0, 5'd7, 1, 0, 0);
    tick();
    check("nochk_exc", out_exc, 1'b0);
    check("nochk_wen", out_wen, 1'b1);
    idle(1, 2);

    // Asynchronous reset with two entries held.
    drive(1, 32'hB1, 0, 0, 5'd4, 1, 0, 0);
    tick();
    drive(1, 32'hB2, 0, 0, 5'd5, 0, 0, 0);
    tick();
    drive(0, '0, 0, 0, '0, 0, 0, 0);
    #1 nRST = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_outputs", {out_result, out_zero, out_neg, out_over, out_wsel, out_wen, out_exc},
          '0);
    check("arst_sticky", ovf_sticky, 1'b0);
    #1 nRST = 1'b1;
    tick();
    drive(1, 32'hC3, 0, 0, 5'd6, 1, 1, 0);
    tick();
    check("resume_result", out_result, 32'hC3);
    idle(1, 2);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom, $urandom % 2, $urandom % 2,
            5'($urandom), $urandom % 2, ($urandom % 3) != 0, ($urandom % 20) == 0);
      tick();
    end
    idle(1, 4);
    check("random_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ex_result_buffer.md
# ex_result_buffer

Two-entry elastic pipeline buffer directly downstream of the ALU: captures `outport`, the `zero`/`neg`/`over` flags and the destination-register write control, then presents them to the memory/writeback stage with a valid/ready handshake. A skid entry lets `in_ready` be driven purely from a register, so the downstream stall path does not combinationally reach the ALU/execute stage. Supports pipeline flush and, optionally, overflow trapping on signed arithmetic.

## Interface
Parameters:
- `DW`, 32, data width; matches `word_t`.
- `RW`, 5, register-select width; matches `regbits_t`.

Ports:
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ALU result valid this cycle.
- `in_ready`  out  1  buffer can accept; registered.
- `in_result`  in  DW  ALU `outport`.
- `in_zero` / `in_neg` / `in_over`  in  1 each  ALU flags.
- `in_chk_over`  in  1  op is signed ADD/SUB; overflow is meaningful.
- `in_wsel`  in  RW  destination register.
- `in_wen`  in  1  register write enable.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer accepts head.
- `out_result` / `out_zero` / `out_neg` / `out_over` / `out_wsel` / `out_wen`  out  as inputs  head entry fields.
- `out_exc`  out  1  head entry raised an overflow trap.
- `flush`  in  1  synchronous discard of all entries.
- `ovf_sticky`  out  1  overflow trap seen since reset.

## Operation
- Storage: `main` (head) and `skid`, each `{valid, result, zero, neg, over, wsel, wen, exc}`.
- `in_ready = !skid.valid`; `out_valid = main.valid`; `out_*` driven from `main`.
- Accept when `in_valid && in_ready`; pop when `out_valid && out_ready`.
- States, encoded by `(main.valid, skid.valid)`:
  - EMPTY (0,0): accept → ONE.
  - ONE (1,0): accept and pop → ONE, incoming entry goes to `main`. Accept only → FULL, incoming entry goes to `skid`. Pop only → EMPTY.
  - FULL (1,1): `in_ready` = 0. Pop → ONE; `skid` moves to `main`.
- (0,1) is unreachable. The bench asserts it never occurs.
- Order is strictly FIFO. No entry is duplicated or dropped except by `flush`.
- `flush`: next edge clears both valid bits. A same-cycle accept is discarded. A same-cycle pop still counts as consumed by downstream.
- Payload registers load only on accept or skid→main move. Otherwise they hold their value, including across `flush`.

## Timing
- Reset (async, `nRST` = 0): all valid bits 0 and all payload fields 0. Results: `out_valid` = 0, `in_ready` = 1, all `out_*` = 0, `out_exc` = 0, `ovf_sticky` = 0.
- Latency: an entry accepted at edge N appears on `out_*` after edge N. It can pop at edge N+1 at the earliest.
- Throughput: 1 entry/cycle sustained while `out_ready` = 1.
- `in_ready` drops the cycle after the skid fills. At most one beat is absorbed after `out_ready` falls.
- `out_*` remain stable while `out_valid && !out_ready`.
- `nRST` asserted mid-transfer discards all entries immediately and asynchronously.

## Configuration
- Macro `EX_OVF_TRAP_EN`.
- Defined:
  - An accepted beat with `in_chk_over && in_over` stores `exc` = 1 and `wen` = 0.
  - `ovf_sticky` sets on the accept edge. It clears only on reset.
  - A flushed trapping beat still sets `ovf_sticky` if it was accepted before the flush edge. A beat accepted on the flush edge itself does not set it.
- Undefined:
  - `exc` is always 0 and `wen` passes through unchanged.
  - `ovf_sticky` is tied 0; the port remains.

## Test plan
- Reset then a single beat (`result` = 0x0000_0005, `wsel` = 3, `wen` = 1) with `out_ready` = 1 → visible after 1 edge with identical fields; `out_valid` drops after the pop edge.
- Stream of 8 beats 0x10..0x17 with `out_ready` = 0 for cycles 2–4 → `in_ready` = 0 exactly while FULL; output order 0x10..0x17 with no loss or duplication.
- FULL state, then `flush` with `in_valid` = 1 → next cycle `out_valid` = 0, `in_ready` = 1; the flushed beat never appears.
- With `EX_OVF_TRAP_EN`: beat `result` = 0x8000_0000, `over` = 1, `chk_over` = 1, `wen` = 1 → `out_exc` = 1, `out_wen` = 0, `ovf_sticky` = 1. Same beat with `chk_over` = 0 → `out_exc` = 0, `out_wen` = 1.
- `nRST` pulsed low mid-stream with 2 entries held → `out_valid` = 0 and `in_ready` = 1 immediately; outputs all 0; normal flow resumes after release.
